// File: rtl/diff_comb_n_pkg.sv
// Shared constants, FSM state type and signed-range helpers for the diff_comb_n streaming differencer.
package diff_comb_n_pkg;

    localparam int N_DEFAULT = 18;
    localparam int M_MAX     = 16;
    localparam int CNT_W     = $clog2(M_MAX);

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // N-bit patterns of the most positive / most negative two's-complement values.
    function automatic logic [63:0] smax_of(input int n);
        return (64'd1 << (n - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] smin_of(input int n);
        return 64'd1 << (n - 1);
    endfunction

endpackage

// File: rtl/diff_comb_n_delay.sv
// sample_delay_line: M-deep sample history with shift enable and synchronous clear; exposes the oldest tap.
module sample_delay_line #(
    parameter int N = 18,
    parameter int M = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         shift_en,
    input  logic [N-1:0] din,
    output logic [N-1:0] tap
);

    logic [N-1:0] hist_q [M];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < M; k++) hist_q[k] <= '0;
        end else if (clear) begin
            for (int k = 0; k < M; k++) hist_q[k] <= '0;
        end else if (shift_en) begin
            hist_q[0] <= din;
            for (int k = 1; k < M; k++) hist_q[k] <= hist_q[k-1];
        end
    end

    assign tap = hist_q[M-1];

endmodule

// File: rtl/diff_comb_n.sv
// diff_comb_n: y[n] = x[n] - x[n-M] mod 2^N with valid/ready handshake and one registered output stage.
// Define DIFF_COMB_SAT_EN to saturate out_data on signed overflow instead of wrapping.
//
// state   | meaning
// ST_FILL | fewer than M samples accepted since rst/clear; history still partly zero
// ST_RUN  | history fully populated; primed=1, fill count frozen
module diff_comb_n
    import diff_comb_n_pkg::*;
#(
    parameter int N = N_DEFAULT,
    parameter int M = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         ovf,
    output logic         primed
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(M - 1);

    logic [N-1:0]     tap;
    logic             accept;
    logic [N:0]       diff_w;
    logic             ovf_d;
    logic [N-1:0]     res_d;
    logic [N-1:0]     out_data_q;
    logic             out_valid_q;
    logic             ovf_q;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign in_ready = !out_valid_q || out_ready;
    // clear wins over a coincident accept: the sample never enters history or output.
    assign accept   = in_valid && in_ready && !clear;

    sample_delay_line #(.N(N), .M(M)) u_delay (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .shift_en (accept),
        .din      (in_data),
        .tap      (tap)
    );

    assign diff_w = {in_data[N-1], in_data} - {tap[N-1], tap};
    assign ovf_d  = diff_w[N] ^ diff_w[N-1];

`ifdef DIFF_COMB_SAT_EN
    localparam logic [N-1:0] SAT_MAX = N'(smax_of(N));
    localparam logic [N-1:0] SAT_MIN = N'(smin_of(N));

    always_comb begin
        res_d = diff_w[N-1:0];
        if (ovf_d) res_d = diff_w[N] ? SAT_MIN : SAT_MAX;
    end
`else
    always_comb begin
        res_d = diff_w[N-1:0];
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (clear) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (accept) begin
            out_data_q  <= res_d;
            out_valid_q <= 1'b1;
            ovf_q       <= ovf_d;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FILL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (clear) begin
            state_d = ST_FILL;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_FILL: begin
                    if (accept) begin
                        if (cnt_q == CNT_LAST) state_d = ST_RUN;
                        else                   cnt_d   = cnt_q + 1'b1;
                    end
                end
                ST_RUN:  state_d = ST_RUN;
                default: state_d = ST_FILL;
            endcase
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign ovf       = ovf_q;
    assign primed    = (state_q == ST_RUN);

endmodule

// File: tb/tb_diff_comb_n.sv
// Directed bench for diff_comb_n: M=1 and M=4 instances share stimulus; table rows plus handshake/clear/reset sequences.
module tb_diff_comb_n;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        in_valid;
    logic [17:0] in_data;
    logic        out_ready;
    logic        in_ready1, out_valid1, ovf1, primed1;
    logic [17:0] out_data1;
    logic        in_ready4, out_valid4, ovf4, primed4;
    logic [17:0] out_data4;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    diff_comb_n #(.N(18), .M(1)) dut1 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
        .ovf(ovf1), .primed(primed1)
    );

    diff_comb_n #(.N(18), .M(4)) dut4 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready4),
        .in_data(in_data), .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
        .ovf(ovf4), .primed(primed4)
    );

    typedef struct {
        logic        restart;
        logic [17:0] din;
        logic [17:0] e1;
        logic        o1;
        logic        p1;
        logic [17:0] e4;
        logic        o4;
        logic        p4;
    } vec_t;

    vec_t vq[$];

`ifdef DIFF_COMB_SAT_EN
    localparam logic [17:0] OVF_RES = 18'h1FFFF;
`else
    localparam logic [17:0] OVF_RES = 18'h3FFFF;
`endif

    function automatic logic [17:0] s18(input int v);
        return v[17:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        in_valid = 1'b0;
        clear    = 1'b1;
        tick();
        clear    = 1'b0;
        chk("clr_valid1", 32'(out_valid1), 32'd0);
        chk("clr_primed1", 32'(primed1), 32'd0);
        chk("clr_valid4", 32'(out_valid4), 32'd0);
        chk("clr_primed4", 32'(primed4), 32'd0);
    endtask

    initial begin
        // restart din e1 o1 p1 e4 o4 p4
        vq.push_back('{1'b1, s18(5),  s18(5),  1'b0, 1'b1, s18(5),  1'b0, 1'b0});
        vq.push_back('{1'b0, s18(12), s18(7),  1'b0, 1'b1, s18(12), 1'b0, 1'b0});
        vq.push_back('{1'b0, s18(12), s18(0),  1'b0, 1'b1, s18(12), 1'b0, 1'b0});
        vq.push_back('{1'b0, s18(30), s18(18), 1'b0, 1'b1, s18(30), 1'b0, 1'b1});
        // running sums of increments 3, -1, 100, 0
        vq.push_back('{1'b1, s18(3),   s18(3),   1'b0, 1'b1, s18(3),   1'b0, 1'b0});
        vq.push_back('{1'b0, s18(2),   s18(-1),  1'b0, 1'b1, s18(2),   1'b0, 1'b0});
        vq.push_back('{1'b0, s18(102), s18(100), 1'b0, 1'b1, s18(102), 1'b0, 1'b0});
        vq.push_back('{1'b0, s18(102), s18(0),   1'b0, 1'b1, s18(102), 1'b0, 1'b1});
        for (int i = 1; i <= 8; i++)
            vq.push_back('{(i == 1), s18(i), s18(1), 1'b0, 1'b1,
                           s18(i > 4 ? 4 : i), 1'b0, (i >= 4)});
        vq.push_back('{1'b1, s18(-131072), s18(-131072), 1'b0, 1'b1, s18(-131072), 1'b0, 1'b0});
        vq.push_back('{1'b0, s18(131071),  OVF_RES,      1'b1, 1'b1, s18(131071),  1'b0, 1'b0});

        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        #12;
        chk("rst_valid", 32'(out_valid1), 32'd0);
        chk("rst_data", 32'(out_data1), 32'd0);
        chk("rst_ovf", 32'(ovf1), 32'd0);
        chk("rst_primed", 32'(primed1), 32'd0);
        chk("rst_in_ready", 32'(in_ready1), 32'd1);
        rst = 1'b0;
        tick();

        foreach (vq[i]) begin
            if (vq[i].restart) do_clear();
            in_valid = 1'b1;
            in_data  = vq[i].din;
            tick();
            chk($sformatf("v%0d_valid", i), 32'(out_valid1), 32'd1);
            chk($sformatf("v%0d_data1", i), 32'(out_data1), 32'(vq[i].e1));
            chk($sformatf("v%0d_ovf1", i), 32'(ovf1), 32'(vq[i].o1));
            chk($sformatf("v%0d_primed1", i), 32'(primed1), 32'(vq[i].p1));
            chk($sformatf("v%0d_data4", i), 32'(out_data4), 32'(vq[i].e4));
            chk($sformatf("v%0d_ovf4", i), 32'(ovf4), 32'(vq[i].o4));
            chk($sformatf("v%0d_primed4", i), 32'(primed4), 32'(vq[i].p4));
        end

        // backpressure: result held, input stalled, nothing lost
        do_clear();
        in_valid = 1'b1; in_data = s18(10);
        tick();
        chk("bp_first", 32'(out_data1), 32'd10);
        out_ready = 1'b0; in_data = s18(25);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("bp_in_ready", 32'(in_ready1), 32'd0);
            chk("bp_valid", 32'(out_valid1), 32'd1);
            chk("bp_hold", 32'(out_data1), 32'd10);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(in_ready1), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("bp_next1", 32'(out_data1), 32'd15);
        chk("bp_next4", 32'(out_data4), 32'd25);
        chk("bp_next_valid", 32'(out_valid1), 32'd1);
        tick();
        chk("drain_valid", 32'(out_valid1), 32'd0);

        // clear together with a valid sample drops it
        clear = 1'b1; in_valid = 1'b1; in_data = s18(9);
        #1;
        chk("clr_in_ready", 32'(in_ready1), 32'd1);
        tick();
        clear = 1'b0; in_valid = 1'b0;
        chk("clr9_valid", 32'(out_valid1), 32'd0);
        chk("clr9_primed", 32'(primed1), 32'd0);
        in_valid = 1'b1; in_data = s18(6);
        tick();
        in_valid = 1'b0;
        chk("after_clr_data", 32'(out_data1), 32'd6);
        chk("after_clr_primed", 32'(primed1), 32'd1);

        // async reset while stalled, between clock edges
        out_ready = 1'b0; in_valid = 1'b1; in_data = s18(7);
        tick();
        chk("pre_rst_valid", 32'(out_valid1), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid1), 32'd0);
        chk("arst_data", 32'(out_data1), 32'd0);
        chk("arst_ovf", 32'(ovf1), 32'd0);
        chk("arst_primed1", 32'(primed1), 32'd0);
        chk("arst_primed4", 32'(primed4), 32'd0);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/diff_comb_n.md
Name: diff_comb_n

Overview:
- Streaming differencer: the inverse of the N-bit sample-timing-offset accumulator.
- Computes y[n] = x[n] − x[n−M] mod 2^N, with history initialised to zero after reset or clear, so an accumulator's running output is turned back into its input increments.
- Sits after accumulatorN outputs, or as the comb stage of integrate/comb decimators in the timing-offset path.
- Valid/ready streaming on both sides; one registered output stage.

Parameters:
- N, 18, sample width in bits (two's complement when interpreted as signed).
- M, 1, differential delay in accepted samples (1..16).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous restart: zero the history, drop pending output.
- in_valid  input  1  in_data holds a sample.
- in_ready  output  1  block accepts a sample this cycle.
- in_data  input  N  sample x[n].
- out_valid  output  1  out_data holds a result.
- out_ready  input  1  downstream accepts the result.
- out_data  output  N  difference y[n].
- ovf  output  1  signed overflow of the registered result; qualified by out_valid.
- primed  output  1  at least M samples accepted since the last rst/clear.

Behaviour:
- Reset (async, rst=1): history all zero, out_valid=0, out_data=0, ovf=0, primed=0, fill count=0, state FILL.
- in_ready = !out_valid || out_ready. It is combinational and does not depend on in_valid.
- Accept when in_valid && in_ready. On the next edge:
  - out_data <= in_data − hist[M−1] (N-bit modulo).
  - out_valid <= 1.
  - History shifts: hist[0] <= in_data, hist[k] <= hist[k−1].
- Latency: one cycle from accept to out_valid.
- Throughput: one sample per cycle while out_ready=1.
- Output holding: if out_valid && !out_ready, out_data and ovf are held stable and no input is accepted.
- Output drain: if out_ready with no accept, out_valid <= 0.
- Accept and drain in the same cycle: out_valid stays 1 with the new data.
- ovf: computed from an (N+1)-bit signed difference; set if the result is outside the N-bit signed range.
- FSM FILL/RUN:
  - FILL: the fill count increments per accept; moving to RUN when count reaches M−1 and an accept occurs.
  - RUN: primed=1; the count is frozen (saturates, never wraps).
  - M=1: the first accept moves the FSM to RUN.
- First M outputs are x[n] − 0 (zero history), which is what exact accumulator inversion requires.
- clear:
  - Takes priority over a simultaneous accept; that sample is dropped and in_ready is still asserted.
  - Zeros history, out_valid, ovf and count; state <= FILL.
- rst mid-stream: immediate return to reset values; no partial output.

Optional Feature:
- Macro DIFF_COMB_SAT_EN.
- Defined: out_data saturates to the signed range, 2^(N−1)−1 or −2^(N−1), when ovf is set.
- Undefined: out_data wraps modulo 2^N (bit-exact inverse of a wrapping accumulator). ovf is still reported.

Decomposition:
- Shared package holds:
  - default N=18 and M limit 16;
  - a clog2-based count-width constant;
  - FSM state typedef (FILL, RUN);
  - signed min/max constant functions of N.
- One sub-module, sample_delay_line (N, M): M-deep shift register with shift-enable and synchronous clear, exposing the tap hist[M−1].

Test Plan:
- M=1, out_ready=1, inputs 5, 12, 12, 30 back-to-back:
  - out_data = 5, 7, 0, 18, each one cycle after accept;
  - primed rises after the first accept.
- Accumulator inversion: drive accumulatorN(N=18) outputs from increments 3, −1, 100, 0 → outputs 3, −1, 100, 0 exactly, ovf=0.
- Backpressure: hold out_ready=0 for 3 cycles after the first result →
  - in_ready=0;
  - out_data held;
  - no sample lost when out_ready returns; ordering preserved.
- M=4: inputs 1..8 → outputs 1, 2, 3, 4, 4, 4, 4, 4; primed rises after the 4th accept.
- Overflow, N=18, M=1: inputs −131072 then 131071 → ovf=1.
  - Without the macro, second output = −1 (wrap).
  - With DIFF_COMB_SAT_EN, second output = 131071.
- clear asserted together with in_valid=1 carrying value 9 → sample dropped, out_valid=0, primed=0.
  - Next input 6 gives out_data=6.
  - Async rst mid-backpressure → all outputs 0 immediately.
